// File: rtl/interrupt_ctrl_pkg.sv
// Shared types and constants for the interrupt controller.
// Holds the FSM state enum, redirect cause codes and default vectors.
package interrupt_ctrl_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        HANDLER = 1'b1
    } state_t;

    localparam logic [1:0] CAUSE_NONE = 2'd0;
    localparam logic [1:0] CAUSE_IRQ  = 2'd1;
    localparam logic [1:0] CAUSE_EXC  = 2'd2;
    localparam logic [1:0] CAUSE_ERET = 2'd3;

    localparam logic [31:0] DEF_IRQ_VECTOR = 32'h8000_0004;
    localparam logic [31:0] DEF_EXC_VECTOR = 32'h8000_0008;

    // Return address for an interrupt: a delay-slot instruction must
    // resume at its branch so the branch is re-executed.
    function automatic logic [31:0] irq_return_pc(
        input logic [31:0] pc,
        input logic        delay_slot
    );
        return delay_slot ? pc - 32'd4 : pc;
    endfunction

endpackage

// File: rtl/interrupt_ctrl_edge.sv
// IRQ rising-edge detector with a single-entry pending latch.
// Ports: clk, reset, IRQ (level), consume (clear request), pending (out).
module irq_edge_latch (
    input  logic clk,
    input  logic reset,
    input  logic IRQ,
    input  logic consume,
    output logic pending
);

    logic irq_d;
    logic edge_seen;

    // irq_d clears on reset, so a level held across reset release
    // is seen as an edge in the first cycle after reset.
    assign edge_seen = IRQ & ~irq_d;

    // A new edge wins over a same-cycle consume.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_d   <= 1'b0;
            pending <= 1'b0;
        end else begin
            irq_d   <= IRQ;
            pending <= edge_seen | (pending & ~consume);
        end
    end

endmodule

// File: rtl/interrupt_ctrl.sv
// Interrupt/exception controller: decides pipeline redirects for IRQ,
// undefined-instruction exceptions and eret. Ports: clk, reset, IRQ,
// pc_ex, ex_valid, ex_delay_slot, stall, exc_req, eret -> redirect,
// redirect_pc, cause, epc, in_handler, irq_pending, double_fault.
module interrupt_ctrl
    import interrupt_ctrl_pkg::*;
#(
    parameter logic [31:0] IRQ_VECTOR = DEF_IRQ_VECTOR,
    parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        IRQ,
    input  logic [31:0] pc_ex,
    input  logic        ex_valid,
    input  logic        ex_delay_slot,
    input  logic        stall,
    input  logic        exc_req,
    input  logic        eret,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic [1:0]  cause,
    output logic [31:0] epc,
    output logic        in_handler,
    output logic        irq_pending,
    output logic        double_fault
);

    state_t      state;
    state_t      state_next;
    logic [31:0] epc_next;
    logic        df_next;
    logic        consume;
    logic        eligible;

    irq_edge_latch u_edge (
        .clk     (clk),
        .reset   (reset),
        .IRQ     (IRQ),
        .consume (consume),
        .pending (irq_pending)
    );

    assign eligible   = ex_valid & ~stall;
    assign in_handler = (state == HANDLER);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            epc          <= '0;
            double_fault <= 1'b0;
        end else begin
            state        <= state_next;
            epc          <= epc_next;
            double_fault <= df_next;
        end
    end

    // Redirect outputs are combinational; reset forces them low.
    always_comb begin
        state_next  = state;
        epc_next    = epc;
        df_next     = double_fault;
        consume     = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        cause       = CAUSE_NONE;
        if (!reset) begin
            case (state)
                IDLE: begin
                    // Exception outranks IRQ; pending is left set.
                    if (eligible && exc_req) begin
                        redirect    = 1'b1;
                        redirect_pc = EXC_VECTOR;
                        cause       = CAUSE_EXC;
                        epc_next    = pc_ex + 32'd4;
                        state_next  = HANDLER;
                    end else if (eligible && irq_pending) begin
                        redirect    = 1'b1;
                        redirect_pc = IRQ_VECTOR;
                        cause       = CAUSE_IRQ;
                        consume     = 1'b1;
                        epc_next    = irq_return_pc(pc_ex, ex_delay_slot);
                        state_next  = HANDLER;
                    end
                end
                HANDLER: begin
                    // No nesting: a fault inside the handler is only
                    // recorded.
                    if (eligible && exc_req) begin
                        df_next = 1'b1;
                    end else if (eligible && eret) begin
                        redirect    = 1'b1;
                        redirect_pc = epc;
                        cause       = CAUSE_ERET;
                        state_next  = IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_interrupt_ctrl.sv
// Scoreboard bench for interrupt_ctrl: directed stimulus pushes the
// expected redirects, a negedge monitor pops and compares them.
module tb_interrupt_ctrl;

    typedef struct {
        logic [31:0] pc;
        logic [1:0]  cause;
        logic [31:0] epc;
        logic        h;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        IRQ;
    logic [31:0] pc_ex;
    logic        ex_valid;
    logic        ex_delay_slot;
    logic        stall;
    logic        exc_req;
    logic        eret;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [1:0]  cause;
    logic [31:0] epc;
    logic        in_handler;
    logic        irq_pending;
    logic        double_fault;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #50 clk = ~clk;

    interrupt_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .IRQ           (IRQ),
        .pc_ex         (pc_ex),
        .ex_valid      (ex_valid),
        .ex_delay_slot (ex_delay_slot),
        .stall         (stall),
        .exc_req       (exc_req),
        .eret          (eret),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .cause         (cause),
        .epc           (epc),
        .in_handler    (in_handler),
        .irq_pending   (irq_pending),
        .double_fault  (double_fault)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, want %h", nm, act, req);
        end
    endtask

    task automatic expect_rd(input logic [31:0] pc, input logic [1:0] c,
                             input logic [31:0] e, input logic h);
        exp_t x;
        x.pc = pc; x.cause = c; x.epc = e; x.h = h;
        exp_q.push_back(x);
    endtask

    // Apply one cycle of inputs, return at posedge+1.
    task automatic cyc(input logic i, input logic [31:0] pc,
                       input logic v, input logic s, input logic ds,
                       input logic x, input logic r);
        IRQ = i; pc_ex = pc; ex_valid = v; stall = s;
        ex_delay_slot = ds; exc_req = x; eret = r;
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare each redirect, then epc/in_handler a cycle later.
    initial begin
        exp_t e;
        logic armed;
        armed = 1'b0;
        e = '{pc: '0, cause: '0, epc: '0, h: 1'b0};
        forever begin
            @(negedge clk);
            if (armed) begin
                chk("epc_after", epc, e.epc);
                chk("in_handler_after", {31'd0, in_handler}, {31'd0, e.h});
                armed = 1'b0;
            end
            if (redirect === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_redirect: pc %h cause %0d, want none",
                             redirect_pc, cause);
                end else begin
                    e = exp_q.pop_front();
                    chk("redirect_pc", redirect_pc, e.pc);
                    chk("cause", {30'd0, cause}, {30'd0, e.cause});
                    armed = 1'b1;
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        IRQ = 0; pc_ex = 0; ex_valid = 1; stall = 0;
        ex_delay_slot = 0; exc_req = 0; eret = 0;
        @(posedge clk);
        #1;
        #10;
        chk("rst_redirect", {31'd0, redirect}, 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'd0);
        chk("rst_cause", {30'd0, cause}, 32'd0);
        chk("rst_epc", epc, 32'd0);
        chk("rst_in_handler", {31'd0, in_handler}, 32'd0);
        chk("rst_pending", {31'd0, irq_pending}, 32'd0);
        chk("rst_double_fault", {31'd0, double_fault}, 32'd0);
        cyc(0, 32'h0, 1, 0, 0, 0, 0);
        reset = 1'b0;

        // Basic IRQ
        cyc(1, 32'h40, 1, 0, 0, 0, 0);
        expect_rd(32'h8000_0004, 2'd1, 32'h40, 1'b1);
        cyc(0, 32'h40, 1, 0, 0, 0, 0);
        expect_rd(32'h40, 2'd3, 32'h40, 1'b0);
        cyc(0, 32'h100, 1, 0, 0, 0, 1);
        cyc(0, 32'h44, 1, 0, 0, 0, 0);

        // IRQ on a delay-slot instruction
        cyc(1, 32'h50, 1, 0, 1, 0, 0);
        expect_rd(32'h8000_0004, 2'd1, 32'h4C, 1'b1);
        cyc(0, 32'h50, 1, 0, 1, 0, 0);
        expect_rd(32'h4C, 2'd3, 32'h4C, 1'b0);
        cyc(0, 32'h104, 1, 0, 0, 0, 1);
        cyc(0, 32'h4C, 1, 0, 0, 0, 0);

        // Exception beats pending IRQ, IRQ follows after eret
        cyc(1, 32'h0, 0, 0, 0, 0, 0);
        expect_rd(32'h8000_0008, 2'd2, 32'h64, 1'b1);
        cyc(0, 32'h60, 1, 0, 0, 1, 0);
        #10;
        chk("pending_kept_after_exc", {31'd0, irq_pending}, 32'd1);
        expect_rd(32'h64, 2'd3, 32'h64, 1'b0);
        cyc(0, 32'h108, 1, 0, 0, 0, 1);
        expect_rd(32'h8000_0004, 2'd1, 32'h68, 1'b1);
        cyc(0, 32'h68, 1, 0, 0, 0, 0);
        expect_rd(32'h68, 2'd3, 32'h68, 1'b0);
        cyc(0, 32'h10C, 1, 0, 0, 0, 1);
        cyc(0, 32'h68, 1, 0, 0, 0, 0);

        // IRQ edge inside handler is taken after eret
        cyc(1, 32'h70, 1, 0, 0, 0, 0);
        expect_rd(32'h8000_0004, 2'd1, 32'h70, 1'b1);
        cyc(0, 32'h70, 1, 0, 0, 0, 0);
        cyc(1, 32'h200, 1, 0, 0, 0, 0);
        expect_rd(32'h70, 2'd3, 32'h70, 1'b0);
        cyc(0, 32'h204, 1, 0, 0, 0, 1);
        expect_rd(32'h8000_0004, 2'd1, 32'h74, 1'b1);
        cyc(0, 32'h74, 1, 0, 0, 0, 0);
        expect_rd(32'h74, 2'd3, 32'h74, 1'b0);
        cyc(0, 32'h300, 1, 0, 0, 0, 1);
        cyc(0, 32'h74, 1, 0, 0, 0, 0);

        // Stall holds off the pending IRQ
        cyc(1, 32'h80, 1, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 32'h80, 1, 1, 0, 0, 0);
        #10;
        chk("pending_under_stall", {31'd0, irq_pending}, 32'd1);
        expect_rd(32'h8000_0004, 2'd1, 32'h80, 1'b1);
        cyc(0, 32'h80, 1, 0, 0, 0, 0);
        expect_rd(32'h80, 2'd3, 32'h80, 1'b0);
        cyc(0, 32'h0, 1, 0, 0, 0, 1);
        cyc(0, 32'h84, 1, 0, 0, 0, 0);

        // Double fault, then eret ignored in IDLE
        cyc(1, 32'h90, 1, 0, 0, 0, 0);
        expect_rd(32'h8000_0004, 2'd1, 32'h90, 1'b1);
        cyc(0, 32'h90, 1, 0, 0, 0, 0);
        cyc(0, 32'h500, 1, 0, 0, 1, 0);
        #10;
        chk("double_fault_set", {31'd0, double_fault}, 32'd1);
        chk("epc_kept_on_df", epc, 32'h90);
        chk("in_handler_on_df", {31'd0, in_handler}, 32'd1);
        expect_rd(32'h90, 2'd3, 32'h90, 1'b0);
        cyc(0, 32'h504, 1, 0, 0, 0, 1);
        cyc(0, 32'h10, 1, 0, 0, 0, 1);
        #10;
        chk("double_fault_sticky", {31'd0, double_fault}, 32'd1);
        chk("eret_idle_state", {31'd0, in_handler}, 32'd0);

        // Edge in the same cycle pending is consumed
        cyc(1, 32'h0, 0, 0, 0, 0, 0);
        cyc(0, 32'h0, 0, 0, 0, 0, 0);
        expect_rd(32'h8000_0004, 2'd1, 32'hA0, 1'b1);
        cyc(1, 32'hA0, 1, 0, 0, 0, 0);
        #10;
        chk("pending_refilled", {31'd0, irq_pending}, 32'd1);
        expect_rd(32'hA0, 2'd3, 32'hA0, 1'b0);
        cyc(0, 32'h0, 1, 0, 0, 0, 1);
        expect_rd(32'h8000_0004, 2'd1, 32'hA8, 1'b1);
        cyc(0, 32'hA8, 1, 0, 0, 0, 0);

        // Reset in HANDLER with pending; IRQ held across release
        cyc(1, 32'h0, 1, 0, 0, 0, 0);
        #10;
        chk("pending_before_rst", {31'd0, irq_pending}, 32'd1);
        chk("handler_before_rst", {31'd0, in_handler}, 32'd1);
        reset = 1'b1;
        cyc(1, 32'h0, 1, 0, 0, 0, 0);
        reset = 1'b0;
        IRQ = 1; ex_valid = 0;
        #10;
        chk("rst_hdl_in_handler", {31'd0, in_handler}, 32'd0);
        chk("rst_hdl_pending", {31'd0, irq_pending}, 32'd0);
        chk("rst_hdl_epc", epc, 32'd0);
        chk("rst_hdl_redirect", {31'd0, redirect}, 32'd0);
        chk("rst_hdl_df", {31'd0, double_fault}, 32'd0);
        @(posedge clk);
        #1;
        expect_rd(32'h8000_0004, 2'd1, 32'hC0, 1'b1);
        cyc(1, 32'hC0, 1, 0, 0, 0, 0);
        expect_rd(32'hC0, 2'd3, 32'hC0, 1'b0);
        cyc(1, 32'h0, 1, 0, 0, 0, 1);
        cyc(0, 32'hC4, 1, 0, 0, 0, 0);
        cyc(0, 32'hC8, 1, 0, 0, 0, 0);
        cyc(0, 32'hCC, 1, 0, 0, 0, 0);

        chk("missing_redirects", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/interrupt_ctrl.md
INTERRUPT_CTRL -- requirements
Module: interrupt_ctrl

Interface
REQ-001 SHALL have parameter IRQ_VECTOR, 32'h8000_0004, handler entry for external interrupt.
REQ-002 SHALL have parameter EXC_VECTOR, 32'h8000_0008, handler entry for undefined-instruction exception.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port IRQ  in  1  external interrupt level; rising edge = request.
REQ-006 SHALL have port pc_ex  in  32  PC of instruction in EX.
REQ-007 SHALL have port ex_valid  in  1  EX holds a real instruction, not a bubble.
REQ-008 SHALL have port ex_delay_slot  in  1  EX instruction sits in a branch delay slot.
REQ-009 SHALL have port stall  in  1  pipeline frozen this cycle.
REQ-010 SHALL have port exc_req  in  1  EX instruction undefined.
REQ-011 SHALL have port eret  in  1  EX instruction is eret.
REQ-012 SHALL have port redirect  out  1  one-cycle pulse: flush IF/ID/EX, load redirect_pc.
REQ-013 SHALL have port redirect_pc  out  32  new fetch PC.
REQ-014 SHALL have port cause  out  2  0 none, 1 irq, 2 exc, 3 eret; valid only with redirect.
REQ-015 SHALL have ports epc  out  32, in_handler  out  1, irq_pending  out  1, double_fault  out  1 (sticky).

Function
REQ-016 SHALL implement states IDLE and HANDLER; in_handler = (state == HANDLER).
REQ-017 SHALL detect IRQ rising edge with a registered copy irq_d; an edge sets pending, holding at most one request.
REQ-018 SHALL define eligible = ex_valid & !stall.
REQ-019 SHALL decide redirect combinationally in cycle N from current state and inputs; epc, state and pending update at the end of cycle N.
REQ-020 In IDLE, eligible & exc_req SHALL redirect to EXC_VECTOR, cause 2, epc <= pc_ex + 4, and go to HANDLER.
REQ-021 In IDLE, eligible & pending & !exc_req SHALL redirect to IRQ_VECTOR, cause 1, clear pending, and go to HANDLER.
REQ-022 The IRQ epc SHALL be pc_ex, or pc_ex - 4 when ex_delay_slot = 1; 32-bit wrap-around arithmetic.
REQ-023 exc_req SHALL take priority over pending IRQ in the same cycle; pending SHALL remain set.
REQ-024 In HANDLER, eligible & eret SHALL redirect to epc, cause 3, and go to IDLE.
REQ-025 In HANDLER, an IRQ edge SHALL set pending without redirect; it is taken at the first eligible IDLE cycle after return.
REQ-026 In HANDLER, eligible & exc_req SHALL set double_fault with no redirect and no epc change.
REQ-027 eret in IDLE SHALL be ignored.
REQ-028 An edge arriving in the same cycle pending is consumed SHALL leave pending = 1.
REQ-029 With stall = 1 or ex_valid = 0, no redirect SHALL occur; pending SHALL persist indefinitely.

Reset
REQ-030 On reset, the block SHALL set: state IDLE; pending, irq_d and double_fault 0; epc 0; redirect 0, redirect_pc 0 and cause 0.
REQ-031 Reset mid-handler or with pending set SHALL discard both.
REQ-032 IRQ held high across reset release SHALL count as an edge in the first cycle after reset.

Structure
REQ-033 Package interrupt_ctrl_pkg SHALL hold the state enum, cause codes and default vector constants.
REQ-034 The edge detector plus pending latch SHALL be sub-module irq_edge_latch (inputs clk, reset, IRQ, consume; output pending).

Verification (100 ns clock)
REQ-035 IRQ pulse of one cycle, ex_valid=1, stall=0, pc_ex=0x0000_0040 -> redirect for 1 cycle with redirect_pc 0x8000_0004, cause 1, epc 0x0000_0040, in_handler 1.
REQ-036 IRQ edge with pc_ex=0x0000_0050 and ex_delay_slot=1 -> epc 0x0000_004C.
REQ-037 exc_req and pending IRQ in the same eligible cycle, pc_ex=0x0000_0060 -> cause 2, redirect_pc 0x8000_0008, epc 0x0000_0064; after eret, an IRQ redirect follows within 2 eligible cycles.
REQ-038 IRQ edge while in HANDLER, then eret with epc=0x0000_0070 -> redirect to 0x0000_0070 with cause 3, then cause 1 at the next eligible cycle.
REQ-039 Pending IRQ with stall=1 for 5 cycles -> no redirect; redirect in the cycle stall falls.
REQ-040 reset asserted in HANDLER with pending=1 -> next cycle in_handler 0, irq_pending 0, epc 0, redirect 0.
